// File: rtl/flit_arbiter.sv
// flit_arbiter: wormhole flit arbiter. Shares one registered flit output
// among N_IN input channels. A packet wins on its head (or single) flit and
// keeps the channel until its tail flit has been accepted, so packets never
// interleave on the output.
//
// Optional feature macro: FARTHEST_FIRST_EN
//   defined   -> in IDLE the header with the largest compare field wins,
//                ties resolved by round-robin priority order.
//   undefined -> pure round-robin; the compare logic is not built.
//
// Flit-type encoding and field positions default to the shared values and
// can be overridden through parameters.
module flit_arbiter #(
    parameter int                    N_IN        = 4,
    parameter int                    FLIT_SIZE   = 32,
    parameter int                    HEADER_LEN  = 2,
    parameter logic [HEADER_LEN-1:0] HEAD_FLIT   = 2'b10,
    parameter logic [HEADER_LEN-1:0] BODY_FLIT   = 2'b00,
    parameter logic [HEADER_LEN-1:0] TAIL_FLIT   = 2'b01,
    parameter logic [HEADER_LEN-1:0] SINGLE_FLIT = 2'b11,
    parameter int                    CMP_POS     = 29,
    parameter int                    CMP_LEN     = 4,
    localparam int                   IW          = $clog2(N_IN)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_IN*FLIT_SIZE-1:0] in_flit,
    input  logic [N_IN-1:0]           in_valid,
    output logic [N_IN-1:0]           in_avail,
    output logic [FLIT_SIZE-1:0]      out,
    output logic                      out_valid,
    input  logic                      out_avail,
    output logic [IW-1:0]             lock_owner,
    output logic                      locked
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    // Channel index base+off, wrapped into 0..N_IN-1.
    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base,
                                               input int unsigned    off);
        int unsigned sum_v;
        sum_v = int'(base) + off;
        return IW'(sum_v % N_IN);
    endfunction

    // A header flit opens arbitration: HEAD or SINGLE.
    function automatic logic is_header(input logic [HEADER_LEN-1:0] ftype);
        return (ftype == HEAD_FLIT) || (ftype == SINGLE_FLIT);
    endfunction

    // Registered state
    state_t               state_r;
    logic [IW-1:0]        rr_r;
    logic [IW-1:0]        owner_r;
    logic                 locked_r;
    logic [FLIT_SIZE-1:0] out_r;
    logic                 out_valid_r;

    // Combinational signals
    state_t                state_nx_s;
    logic [IW-1:0]         rr_nx_s;
    logic [IW-1:0]         owner_nx_s;
    logic                  load_en_s;
    logic [FLIT_SIZE-1:0]  flit_s [N_IN];
    logic [HEADER_LEN-1:0] type_s [N_IN];
    logic [N_IN-1:0]       cand_s;
    logic                  win_found_s;
    logic [IW-1:0]         win_idx_s;
    logic [N_IN-1:0]       grant_s;
    logic                  xfer_s;
    logic [FLIT_SIZE-1:0]  sel_flit_s;
`ifdef FARTHEST_FIRST_EN
    logic [CMP_LEN-1:0]    cmp_s [N_IN];
    logic [CMP_LEN-1:0]    best_cmp_s;
`endif

    // The output register can take a new flit when empty or draining.
    assign load_en_s = ~out_valid_r | out_avail;

    // Split the input bus into per-channel flits, types and header candidates.
    always_comb begin
        for (int i = 0; i < N_IN; i++) begin
            flit_s[i] = in_flit[i*FLIT_SIZE +: FLIT_SIZE];
            type_s[i] = flit_s[i][FLIT_SIZE-1 -: HEADER_LEN];
            cand_s[i] = in_valid[i] & is_header(type_s[i]);
`ifdef FARTHEST_FIRST_EN
            cmp_s[i]  = flit_s[i][CMP_POS -: CMP_LEN];
`endif
        end
    end

    // Pick the IDLE winner by walking channels in round-robin priority order.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = '0;
`ifdef FARTHEST_FIRST_EN
        best_cmp_s  = '0;
`endif
        for (int k = 0; k < N_IN; k++) begin
            if (cand_s[wrap_add(rr_r, k)]) begin
`ifdef FARTHEST_FIRST_EN
                // Strictly greater keeps the earliest tied channel.
                if (!win_found_s || (cmp_s[wrap_add(rr_r, k)] > best_cmp_s)) begin
                    win_found_s = 1'b1;
                    win_idx_s   = wrap_add(rr_r, k);
                    best_cmp_s  = cmp_s[wrap_add(rr_r, k)];
                end else begin
                    win_found_s = win_found_s;
                end
`else
                if (!win_found_s) begin
                    win_found_s = 1'b1;
                    win_idx_s   = wrap_add(rr_r, k);
                end else begin
                    win_found_s = win_found_s;
                end
`endif
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // FSM next state, grants and selected flit.
    always_comb begin
        state_nx_s = state_r;
        rr_nx_s    = rr_r;
        owner_nx_s = owner_r;
        grant_s    = '0;
        xfer_s     = 1'b0;
        sel_flit_s = '0;
        case (state_r)
            ST_IDLE: begin
                if (load_en_s && win_found_s) begin
                    grant_s[win_idx_s] = 1'b1;
                    xfer_s             = 1'b1;
                    sel_flit_s         = flit_s[win_idx_s];
                    if (type_s[win_idx_s] == HEAD_FLIT) begin
                        state_nx_s = ST_LOCKED;
                        owner_nx_s = win_idx_s;
                    end else begin
                        // Single-flit packet: arbitration moves past the winner.
                        rr_nx_s = wrap_add(win_idx_s, 1);
                    end
                end else begin
                    xfer_s = 1'b0;
                end
            end
            ST_LOCKED: begin
                // Only the owner may send; a repeated HEAD counts as body.
                grant_s[owner_r] = load_en_s;
                if (load_en_s && in_valid[owner_r]) begin
                    xfer_s     = 1'b1;
                    sel_flit_s = flit_s[owner_r];
                    if (type_s[owner_r] == TAIL_FLIT) begin
                        state_nx_s = ST_IDLE;
                        rr_nx_s    = wrap_add(owner_r, 1);
                    end else begin
                        state_nx_s = ST_LOCKED;
                    end
                end else begin
                    xfer_s = 1'b0;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Grants are suppressed while reset is held.
    assign in_avail = rst ? '0 : grant_s;

    // Arbitration state: FSM, round-robin pointer and packet owner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            rr_r     <= '0;
            owner_r  <= '0;
            locked_r <= 1'b0;
        end else begin
            state_r  <= state_nx_s;
            rr_r     <= rr_nx_s;
            owner_r  <= owner_nx_s;
            locked_r <= (state_nx_s == ST_LOCKED);
        end
    end

    // One-flit output stage: a load wins over a drain in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_r       <= '0;
            out_valid_r <= 1'b0;
        end else if (xfer_s) begin
            out_r       <= sel_flit_s;
            out_valid_r <= 1'b1;
        end else if (out_valid_r && out_avail) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign out        = out_r;
    assign out_valid  = out_valid_r;
    assign lock_owner = owner_r;
    assign locked     = locked_r;

endmodule

// File: tb/tb_flit_arbiter.sv
// Scoreboard bench for flit_arbiter: directed packets are loaded per channel,
// the hand-derived output order is queued, and a monitor compares every
// output transfer against the queue.
module tb_flit_arbiter;

    localparam int N  = 4;
    localparam int FS = 32;
    localparam logic [1:0] TH = 2'b10;
    localparam logic [1:0] TB = 2'b00;
    localparam logic [1:0] TT = 2'b01;
    localparam logic [1:0] TS = 2'b11;

    logic            clk;
    logic            rst;
    logic [N*FS-1:0] in_flit;
    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_avail;
    logic [FS-1:0]   out;
    logic            out_valid;
    logic            out_avail;
    logic [1:0]      lock_owner;
    logic            locked;

    int errors = 0;
    int checks = 0;

    logic [FS-1:0] sb [$];
    logic [FS-1:0] ch_mem [N][8];
    int            ch_len [N];
    int            ch_pos [N];
    logic [N-1:0]  last_acc;

    flit_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .in_flit    (in_flit),
        .in_valid   (in_valid),
        .in_avail   (in_avail),
        .out        (out),
        .out_valid  (out_valid),
        .out_avail  (out_avail),
        .lock_owner (lock_owner),
        .locked     (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [FS-1:0] mk(input logic [1:0] t, input int ch,
                                         input int seq, input int cmp);
        logic [3:0]  c4;
        logic [7:0]  ch8;
        logic [15:0] s16;
        c4  = cmp[3:0];
        ch8 = ch[7:0];
        s16 = seq[15:0];
        return {t, c4, 2'b00, ch8, s16};
    endfunction

    task automatic check(input string name, input logic [FS-1:0] act,
                         input logic [FS-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic ld(input int ch, input logic [FS-1:0] f);
        ch_mem[ch][ch_len[ch]] = f;
        ch_len[ch]++;
    endtask

    task automatic clear_ch();
        for (int i = 0; i < N; i++) begin
            ch_len[i] = 0;
            ch_pos[i] = 0;
        end
    endtask

    task automatic present();
        for (int i = 0; i < N; i++) begin
            if (ch_pos[i] < ch_len[i]) begin
                in_valid[i]         = 1'b1;
                in_flit[i*FS +: FS] = ch_mem[i][ch_pos[i]];
            end else begin
                in_valid[i]         = 1'b0;
                in_flit[i*FS +: FS] = '0;
            end
        end
    endtask

    function automatic logic pending();
        logic p;
        p = 1'b0;
        for (int i = 0; i < N; i++) if (ch_pos[i] < ch_len[i]) p = 1'b1;
        return p;
    endfunction

    // One clock: called at posedge+1, returns at the next posedge+1.
    task automatic cyc();
        @(negedge clk);
        last_acc = in_valid & in_avail;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) if (last_acc[i]) ch_pos[i]++;
        present();
    endtask

    task automatic drain(input string name, input int budget, output int to_empty);
        int n;
        n = 0;
        to_empty = -1;
        while ((pending() || sb.size() != 0) && n < budget) begin
            cyc();
            n++;
            if (!pending() && to_empty < 0) to_empty = n;
        end
        if (pending() || sb.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL %s_timeout: got %0d flits left expected 0", name, sb.size());
        end
    endtask

    // Monitor: every output transfer must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && out_valid && out_avail) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL out_unexpected: got %h expected none", out);
            end else begin
                logic [FS-1:0] e;
                e = sb.pop_front();
                if (out !== e) begin
                    errors++;
                    $display("FAIL out_flit: got %h expected %h", out, e);
                end
            end
        end
    end

    initial begin
        int n;
        rst       = 1'b1;
        out_avail = 1'b1;
        in_valid  = '0;
        in_flit   = '0;
        clear_ch();

        // ---- reset state, grants masked while reset is high
        for (int i = 0; i < N; i++) ld(i, mk(TS, i, 0, 0));
        ld(0, mk(TS, 0, 1, 0));
        present();
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_avail", {28'd0, in_avail}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out", out, 32'd0);
        check("rst_locked", {31'd0, locked}, 32'd0);
        check("rst_owner", {30'd0, lock_owner}, 32'd0);
        rst = 1'b0;
        present();

        // ---- test 1: singles on all channels, round-robin 0,1,2,3,0
        sb.push_back(mk(TS, 0, 0, 0));
        sb.push_back(mk(TS, 1, 0, 0));
        sb.push_back(mk(TS, 2, 0, 0));
        sb.push_back(mk(TS, 3, 0, 0));
        sb.push_back(mk(TS, 0, 1, 0));
        cyc();
        check("t1_first_acc", {28'd0, last_acc}, 32'h1);
        check("t1_latency_valid", {31'd0, out_valid}, 32'd1);
        check("t1_latency_flit", out, mk(TS, 0, 0, 0));
        drain("t1", 40, n);
        check("t1_throughput", n + 1, 32'd5);

        // ---- test 2: ch1 packet contiguous, then ch2, then ch0 (rr=1)
        clear_ch();
        ld(1, mk(TH, 1, 0, 0)); ld(1, mk(TB, 1, 1, 0));
        ld(1, mk(TB, 1, 2, 0)); ld(1, mk(TT, 1, 3, 0));
        ld(0, mk(TH, 0, 0, 0)); ld(0, mk(TT, 0, 1, 0));
        ld(2, mk(TH, 2, 0, 0)); ld(2, mk(TT, 2, 1, 0));
        present();
        sb.push_back(mk(TH, 1, 0, 0)); sb.push_back(mk(TB, 1, 1, 0));
        sb.push_back(mk(TB, 1, 2, 0)); sb.push_back(mk(TT, 1, 3, 0));
        sb.push_back(mk(TH, 2, 0, 0)); sb.push_back(mk(TT, 2, 1, 0));
        sb.push_back(mk(TH, 0, 0, 0)); sb.push_back(mk(TT, 0, 1, 0));
        drain("t2", 40, n);
        check("t2_cycles", n, 32'd8);

        // ---- test 3: backpressure mid-packet on ch0
        clear_ch();
        ld(0, mk(TH, 0, 0, 0)); ld(0, mk(TB, 0, 1, 0));
        ld(0, mk(TB, 0, 2, 0)); ld(0, mk(TT, 0, 3, 0));
        present();
        sb.push_back(mk(TH, 0, 0, 0)); sb.push_back(mk(TB, 0, 1, 0));
        sb.push_back(mk(TB, 0, 2, 0)); sb.push_back(mk(TT, 0, 3, 0));
        cyc();
        cyc();
        out_avail = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            check("t3_stall_avail", {28'd0, in_avail}, 32'd0);
            check("t3_stall_valid", {31'd0, out_valid}, 32'd1);
            check("t3_stall_out", out, mk(TB, 0, 1, 0));
        end
        out_avail = 1'b1;
        drain("t3", 40, n);

        // ---- test 4: ch3 tail then ch0 head the very next cycle (rr=1)
        clear_ch();
        ld(3, mk(TH, 3, 0, 0)); ld(3, mk(TT, 3, 1, 0));
        ld(0, mk(TH, 0, 0, 0)); ld(0, mk(TT, 0, 1, 0));
        present();
        sb.push_back(mk(TH, 3, 0, 0)); sb.push_back(mk(TT, 3, 1, 0));
        sb.push_back(mk(TH, 0, 0, 0)); sb.push_back(mk(TT, 0, 1, 0));
        cyc();
        check("t4_acc_head3", {28'd0, last_acc}, 32'h8);
        check("t4_locked3", {31'd0, locked}, 32'd1);
        check("t4_owner3", {30'd0, lock_owner}, 32'd3);
        cyc();
        check("t4_acc_tail3", {28'd0, last_acc}, 32'h8);
        check("t4_unlocked", {31'd0, locked}, 32'd0);
        cyc();
        check("t4_acc_head0", {28'd0, last_acc}, 32'h1);
        check("t4_locked0", {31'd0, locked}, 32'd1);
        check("t4_owner0", {30'd0, lock_owner}, 32'd0);
        drain("t4", 40, n);

        // ---- test 5: move rr to 3 with a ch2 single, then three headers
        clear_ch();
        ld(2, mk(TS, 2, 9, 0));
        present();
        sb.push_back(mk(TS, 2, 9, 0));
        drain("t5a", 20, n);
        clear_ch();
        ld(0, mk(TH, 0, 0, 5)); ld(0, mk(TT, 0, 1, 0));
        ld(2, mk(TH, 2, 0, 9)); ld(2, mk(TT, 2, 1, 0));
        ld(3, mk(TH, 3, 0, 9)); ld(3, mk(TT, 3, 1, 0));
        present();
        sb.push_back(mk(TH, 3, 0, 9)); sb.push_back(mk(TT, 3, 1, 0));
`ifdef FARTHEST_FIRST_EN
        sb.push_back(mk(TH, 2, 0, 9)); sb.push_back(mk(TT, 2, 1, 0));
        sb.push_back(mk(TH, 0, 0, 5)); sb.push_back(mk(TT, 0, 1, 0));
`else
        sb.push_back(mk(TH, 0, 0, 5)); sb.push_back(mk(TT, 0, 1, 0));
        sb.push_back(mk(TH, 2, 0, 9)); sb.push_back(mk(TT, 2, 1, 0));
`endif
        drain("t5b", 40, n);

        // ---- test 6: asynchronous reset mid-packet on ch1
        clear_ch();
        ld(1, mk(TH, 1, 0, 0)); ld(1, mk(TB, 1, 1, 0));
        ld(1, mk(TB, 1, 2, 0)); ld(1, mk(TT, 1, 3, 0));
        present();
        sb.push_back(mk(TH, 1, 0, 0));
        cyc();
        cyc();
        check("t6_pre_locked", {31'd0, locked}, 32'd1);
        check("t6_pre_owner", {30'd0, lock_owner}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_valid", {31'd0, out_valid}, 32'd0);
        check("t6_rst_locked", {31'd0, locked}, 32'd0);
        check("t6_rst_avail", {28'd0, in_avail}, 32'd0);
        check("t6_sb_head_out", sb.size(), 32'd0);
        sb.delete();
        clear_ch();
        present();
        @(posedge clk);
        #1;
        ld(0, mk(TS, 0, 7, 0));
        ld(3, mk(TS, 3, 7, 0));
        rst = 1'b0;
        present();
        sb.push_back(mk(TS, 0, 7, 0));
        sb.push_back(mk(TS, 3, 7, 0));
        cyc();
        check("t6_post_acc", {28'd0, last_acc}, 32'h1);
        drain("t6", 20, n);

        check("end_sb_empty", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/flit_arbiter.md
# flit_arbiter

Wormhole flit arbiter: shares one flit output channel among N_IN input channels so that packets never interleave. A packet wins on its head (or single) flit and holds the channel until its tail flit has passed. It sits in front of a router output port or reduction stage and feeds it through a one-flit registered output stage. It uses the codebase valid/avail flit handshake and the flit-type encoding from para.sv.

## Interface
- N_IN, 4: number of input channels, 2..16.
- FLIT_SIZE, HEADER_LEN, HEAD_FLIT, BODY_FLIT, TAIL_FLIT, SINGLE_FLIT, CMP_POS, CMP_LEN: from para.sv.
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- in_flit  in  N_IN*FLIT_SIZE  input flits; channel i occupies bits [i*FLIT_SIZE +: FLIT_SIZE].
- in_valid  in  N_IN  channel i presents a flit.
- in_avail  out  N_IN  arbiter accepts channel i this cycle; combinational.
- out  out  FLIT_SIZE  registered output flit.
- out_valid  out  1  out holds a flit.
- out_avail  in  1  downstream accepts out this cycle.
- lock_owner  out  $clog2(N_IN)  current packet owner; valid while locked.
- locked  out  1  FSM is in LOCKED.

## Operation
- Flit type: bits [FLIT_SIZE-1 -: HEADER_LEN]. A header is HEAD_FLIT or SINGLE_FLIT.
- Input transfer on channel i: in_valid[i] && in_avail[i]. Output transfer: out_valid && out_avail.
- load_en = ~out_valid || out_avail.
- in_avail is one-hot or zero, and is forced to 0 while rst is high.
- Round-robin pointer rr, range 0..N_IN-1. Priority order is rr, rr+1, … modulo N_IN.
- FSM states:
  - IDLE:
    - Candidates are channels with in_valid=1 carrying a header flit. Non-header flits in IDLE are not accepted; the channel stalls.
    - If load_en and any candidate exists, the winner w is the first candidate in priority order, and in_avail[w]=1.
    - Accepted HEAD_FLIT: go to LOCKED, owner=w.
    - Accepted SINGLE_FLIT: stay in IDLE, rr<=w+1 mod N_IN.
  - LOCKED:
    - in_avail[owner] = load_en. All other channels get 0.
    - Any flit type from the owner is forwarded. A HEAD_FLIT from the owner is treated as body.
    - Accepted TAIL_FLIT: go to IDLE, rr<=owner+1 mod N_IN.
- Output register:
  - On input transfer, out<=flit and out_valid<=1.
  - Else, on output transfer, out_valid<=0.
  - out holds its value while out_valid && ~out_avail.
- Simultaneous events:
  - Output drain and new input load in the same cycle: the load wins and out_valid stays 1.
  - Tail accepted in cycle t: a new header from any channel can be accepted in cycle t+1.
- Reset mid-packet: the lock and the partial packet state are dropped, FSM returns to IDLE. Upstream must also be reset.

## Timing
- Reset values: out=0, out_valid=0, rr=0, FSM=IDLE, locked=0, lock_owner=0. in_avail=0 while rst is high.
- Latency: input transfer in cycle t gives out_valid=1 with that flit in cycle t+1.
- Throughput: 1 flit/cycle when out_avail is held high.
- Combinational paths: in_valid/in_flit/out_avail to in_avail. No path from input to out.
- lock_owner and locked are registered. They update in the cycle after the head or tail transfer.

## Configuration
- FARTHEST_FIRST_EN defined:
  - In IDLE, the winner is the candidate with the largest in_flit[CMP_POS -: CMP_LEN], compared unsigned.
  - Ties go to the first tied channel in round-robin priority order.
  - rr is updated exactly as in plain mode.
- FARTHEST_FIRST_EN undefined: pure round-robin. The compare logic is not built.
- LOCKED behaviour is identical in both modes.

## Test plan
- Reset, then SINGLE_FLIT on all 4 channels continuously, out_avail=1 -> out shows channels 0,1,2,3,0 on consecutive cycles, starting 1 cycle after the first accept.
- Ch1 sends HEAD, BODY, BODY, TAIL while ch0 and ch2 hold HEAD -> 4 ch1 flits are contiguous on out. Next grant goes to ch2 (rr=2), then ch0.
- Ch0 mid-packet, out_avail=0 for 3 cycles -> out and out_valid are stable, in_avail=0 on all channels. On release, the flow resumes with no flit lost or duplicated.
- Ch3 TAIL accepted, ch0 HEAD waiting -> ch0 HEAD is accepted in the very next cycle and locked=1 with lock_owner=0 one cycle later.
- FARTHEST_FIRST_EN on: ch0 HEAD cmp=5, ch2 HEAD cmp=9, ch3 HEAD cmp=9, rr=3 -> ch3 wins, then ch2, then ch0. With the macro off and rr=3, the order is ch3, ch0, ch2.
- rst asserted asynchronously mid-packet -> out_valid drops immediately, locked=0. The first post-reset grant follows rr=0 priority.
